// File: rtl/bus_arbiter_pkg.sv
// Shared bus definitions for the SoC bus arbiter.
//   - bus_owner_t / BUS_OWNER_MASTER_0..3 : owner index encoding (BUS_OWNER_BUS is [1:0])
//   - BUS_MASTER_CH                       : number of bus masters
//   - ENABLE_ / DISABLE_                  : active-low grant levels
//   - owner_onehot()                      : owner index -> active-high one-hot vector
package bus_arbiter_pkg;

  localparam int BUS_MASTER_CH = 4;

  typedef logic [1:0] bus_owner_t;

  localparam bus_owner_t BUS_OWNER_MASTER_0 = 2'h0;
  localparam bus_owner_t BUS_OWNER_MASTER_1 = 2'h1;
  localparam bus_owner_t BUS_OWNER_MASTER_2 = 2'h2;
  localparam bus_owner_t BUS_OWNER_MASTER_3 = 2'h3;

  // Grant strobes are active-low.
  localparam logic ENABLE_  = 1'b0;
  localparam logic DISABLE_ = 1'b1;

  function automatic logic [BUS_MASTER_CH-1:0] owner_onehot(input bus_owner_t owner);
    logic [BUS_MASTER_CH-1:0] onehot;
    case (owner)
      BUS_OWNER_MASTER_0: onehot = 4'b0001;
      BUS_OWNER_MASTER_1: onehot = 4'b0010;
      BUS_OWNER_MASTER_2: onehot = 4'b0100;
      BUS_OWNER_MASTER_3: onehot = 4'b1000;
      default:            onehot = 4'b0001;
    endcase
    return onehot;
  endfunction

endpackage

// File: rtl/bus_arb_rr_pick.sv
// Combinational round-robin next-owner selection.
//   req          : active-high request vector, one bit per master
//   owner        : current owner index
//   force_rotate : ignore the owner's own request and search onward from owner+1
//   next_owner   : owner index to register on the next edge
// Search order is owner+1, owner+2, owner+3, owner (mod 4); with no request the
// current owner is returned so the bus parks on it.
module bus_arb_rr_pick
  import bus_arbiter_pkg::*;
(
  input  logic [BUS_MASTER_CH-1:0] req,
  input  bus_owner_t               owner,
  input  logic                     force_rotate,
  output bus_owner_t               next_owner
);

  // cand[k] is the k-th index examined; cand[3] wraps back to the owner itself,
  // so the owner is only re-selected when nobody else is asking.
  bus_owner_t               cand [BUS_MASTER_CH];
  logic [BUS_MASTER_CH-1:0] rot_req;

  genvar gi;
  generate
    for (gi = 0; gi < BUS_MASTER_CH; gi++) begin : g_rot
      assign cand[gi]    = owner + bus_owner_t'(gi + 1);
      assign rot_req[gi] = req[cand[gi]];
    end
  endgenerate

  always_comb begin
    next_owner = owner;
    if (!(req[owner] && !force_rotate)) begin
      // Descending scan so the earliest candidate in rotation order wins.
      for (int k = BUS_MASTER_CH - 1; k >= 0; k--) begin
        if (rot_req[k]) begin
          next_owner = cand[k];
        end
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Four-master round-robin, non-preemptive bus arbiter.
//   clk          : system clock, rising edge
//   reset        : asynchronous, active-low
//   mN_req_n     : master N bus request, active-low
//   mN_grnt_n    : master N grant, active-low; exactly one is low at all times
//   bus_owner    : current owner index, select for the master-side bus mux
// Optional feature macro BUS_ARB_TIMEOUT_EN: a hold counter forces rotation once
// the owner has kept the bus for MAX_HOLD cycles while another master waits.
// Grants are decoded only from the owner register, so there is no combinational
// path from any request to any grant.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int MAX_HOLD   = 16,
  parameter int HOLD_CNT_W = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       m0_req_n,
  input  logic       m1_req_n,
  input  logic       m2_req_n,
  input  logic       m3_req_n,
  output logic       m0_grnt_n,
  output logic       m1_grnt_n,
  output logic       m2_grnt_n,
  output logic       m3_grnt_n,
  output logic [1:0] bus_owner
);

  if (MAX_HOLD < 2 || MAX_HOLD > 65535 || HOLD_CNT_W < 2 ||
      (longint'(1) << HOLD_CNT_W) <= longint'(MAX_HOLD)) begin : g_bad_cfg
    $error("bus_arbiter: illegal MAX_HOLD / HOLD_CNT_W combination");
  end

  logic [BUS_MASTER_CH-1:0] req;
  logic [BUS_MASTER_CH-1:0] owner_oh;
  logic [BUS_MASTER_CH-1:0] grnt_n;
  bus_owner_t               owner_reg;
  bus_owner_t               next_owner;
  logic                     force_rotate;

  assign req      = ~{m3_req_n, m2_req_n, m1_req_n, m0_req_n};
  assign owner_oh = owner_onehot(owner_reg);

`ifdef BUS_ARB_TIMEOUT_EN
  localparam logic [HOLD_CNT_W-1:0] HOLD_LAST = HOLD_CNT_W'(MAX_HOLD - 1);

  logic [HOLD_CNT_W-1:0] hold_cnt_reg;
  logic                  others_req;

  assign others_req   = |(req & ~owner_oh);
  assign force_rotate = (hold_cnt_reg == HOLD_LAST) && others_req;

  // Counts consecutive kept-with-request edges; saturates so a lone owner keeps
  // the bus and is preempted on the first edge another master shows up.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold_cnt_reg <= '0;
    end else if ((next_owner != owner_reg) || !req[owner_reg]) begin
      hold_cnt_reg <= '0;
    end else if (hold_cnt_reg != HOLD_LAST) begin
      hold_cnt_reg <= hold_cnt_reg + 1'b1;
    end
  end
`else
  assign force_rotate = 1'b0;
`endif

  bus_arb_rr_pick u_pick (
    .req          (req),
    .owner        (owner_reg),
    .force_rotate (force_rotate),
    .next_owner   (next_owner)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      owner_reg <= BUS_OWNER_MASTER_0;
    end else begin
      owner_reg <= next_owner;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < BUS_MASTER_CH; gi++) begin : g_grant
      assign grnt_n[gi] = owner_oh[gi] ? ENABLE_ : DISABLE_;
    end
  endgenerate

  assign m0_grnt_n = grnt_n[0];
  assign m1_grnt_n = grnt_n[1];
  assign m2_grnt_n = grnt_n[2];
  assign m3_grnt_n = grnt_n[3];
  assign bus_owner = owner_reg;

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: reference model plus directed scenarios.
module tb_bus_arbiter;

  localparam int MAXH = 4;
`ifdef BUS_ARB_TIMEOUT_EN
  localparam bit TMO = 1'b1;
`else
  localparam bit TMO = 1'b0;
`endif

  logic       clk   = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] req_n = 4'hF;
  logic       m0_grnt_n, m1_grnt_n, m2_grnt_n, m3_grnt_n;
  logic [1:0] bus_owner;

  int n_checks = 0;
  int n_fail   = 0;

  bus_arbiter #(.MAX_HOLD(MAXH), .HOLD_CNT_W(3)) dut (
    .clk       (clk),
    .reset     (reset),
    .m0_req_n  (req_n[0]),
    .m1_req_n  (req_n[1]),
    .m2_req_n  (req_n[2]),
    .m3_req_n  (req_n[3]),
    .m0_grnt_n (m0_grnt_n),
    .m1_grnt_n (m1_grnt_n),
    .m2_grnt_n (m2_grnt_n),
    .m3_grnt_n (m3_grnt_n),
    .bus_owner (bus_owner)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: owner as an integer, rotation search by modular arithmetic.
  int m_owner = 0;
  int m_hold  = 0;

  always @(posedge clk or negedge reset) begin
    logic [3:0] r;
    bit others, frc;
    int nxt;
    if (!reset) begin
      m_owner = 0;
      m_hold  = 0;
    end else begin
      r = ~req_n;
      others = 0;
      for (int k = 1; k < 4; k++) if (r[(m_owner + k) % 4]) others = 1;
      frc = TMO && (m_hold == MAXH - 1) && others;
      nxt = m_owner;
      if (!(r[m_owner] && !frc)) begin
        for (int k = 1; k <= 4; k++) begin
          if (r[(m_owner + k) % 4]) begin
            nxt = (m_owner + k) % 4;
            break;
          end
        end
      end
      if (TMO) begin
        if (nxt != m_owner || !r[m_owner]) m_hold = 0;
        else if (m_hold < MAXH - 1)        m_hold = m_hold + 1;
      end
      m_owner = nxt;
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    logic [3:0] exp_g;
    if (reset) begin
      exp_g = ~(4'b0001 << m_owner);
      check("model_owner", {30'd0, bus_owner}, m_owner);
      check("model_grants", {28'd0, m3_grnt_n, m2_grnt_n, m1_grnt_n, m0_grnt_n}, {28'd0, exp_g});
    end
  end

  task automatic wait_owner(input int who, input string name);
    int cyc = 0;
    while (bus_owner != who[1:0] && cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    check(name, {30'd0, bus_owner}, who);
  endtask

  initial begin
    int exp_seq[5] = '{1, 2, 3, 0, 1};
    int seq[5];
    int nchg, age, prev, owned;

    // Reset state while reset is held low.
    repeat (2) @(negedge clk);
    check("rst_owner", {30'd0, bus_owner}, 0);
    check("rst_grants", {28'd0, m3_grnt_n, m2_grnt_n, m1_grnt_n, m0_grnt_n}, 32'hE);
    reset = 1'b1;

    // Idle parking on master 0.
    repeat (5) begin
      @(negedge clk);
      check("idle_owner", {30'd0, bus_owner}, 0);
      check("idle_m0_grnt", {31'd0, m0_grnt_n}, 0);
    end

    // Single request from master 2: grant visible one cycle later.
    req_n = 4'b1011;
    @(negedge clk);
    check("m2_owner", {30'd0, bus_owner}, 2);
    check("m2_grnt", {31'd0, m2_grnt_n}, 0);

    // Back to owner 0, then all masters requesting with 3-cycle tenures.
    req_n = 4'b1110;
    @(negedge clk);
    check("m0_back", {30'd0, bus_owner}, 0);
    req_n = 4'b0000;
    prev = 0; age = 1; nchg = 0;
    for (int cyc = 0; cyc < 100 && nchg < 5; cyc++) begin
      @(negedge clk);
      req_n = 4'b0000;
      if (bus_owner != prev[1:0]) begin
        check("rr_tenure", age, 3);
        seq[nchg] = bus_owner;
        nchg++;
        prev = bus_owner;
        age = 1;
      end else begin
        age++;
      end
      if (age == 3 && nchg < 5) req_n[bus_owner] = 1'b1;
    end
    check("rr_changes", nchg, 5);
    for (int i = 0; i < 5; i++) check("rr_sequence", seq[i], exp_seq[i]);

    // Owner 3 holds while master 1 waits.
    req_n = 4'b0111;
    wait_owner(3, "m3_owner");
    req_n = 4'b0101;
    repeat (40) begin
      @(negedge clk);
      if (!TMO) check("m3_hold", {30'd0, bus_owner}, 3);
    end
    req_n = 4'b1101;
    @(negedge clk);
    if (!TMO) check("m3_release_to_m1", {30'd0, bus_owner}, 1);

    // Owner 0 holding with master 1 waiting: preempted only with the timeout.
    req_n = 4'b1110;
    wait_owner(0, "m0_owner");
    req_n = 4'b1100;
    owned = 1;
    for (int cyc = 0; cyc < 30; cyc++) begin
      @(negedge clk);
      if (bus_owner != 2'd0) break;
      owned++;
    end
    if (TMO) begin
      check("tmo_owned_cycles", owned, MAXH);
      check("tmo_new_owner", {30'd0, bus_owner}, 1);
    end else begin
      check("no_preempt_owner", {30'd0, bus_owner}, 0);
    end
    // Master 1 idle: owner 0 keeps the bus.
    req_n = 4'b1110;
    @(negedge clk);
    repeat (30) begin
      @(negedge clk);
      check("m0_keeps", {30'd0, bus_owner}, 0);
    end

    // Asynchronous reset mid-cycle while master 2 owns the bus.
    req_n = 4'b1011;
    wait_owner(2, "m2_before_rst");
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check("async_rst_owner", {30'd0, bus_owner}, 0);
    check("async_rst_m0", {31'd0, m0_grnt_n}, 0);
    check("async_rst_m2", {31'd0, m2_grnt_n}, 1);
    @(negedge clk);
    req_n = 4'b1100;
    reset = 1'b1;
    repeat (12) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Round-robin arbiter for the shared SoC bus. It grants the bus to one of four masters at a time.
- It also drives the owner index that the master-side bus multiplexer uses to route the winning master's address, control and write data onto the shared bus. The slave chip-select decoder then consumes that shared address.
- Arbitration is non-preemptive: the owner keeps the bus while it holds its request, except when the optional hold-timeout feature forces rotation.

Parameters:
- MAX_HOLD, 16: maximum consecutive owned cycles before forced rotation. Used only with the optional feature; legal range 2..65535.
- HOLD_CNT_W, 16: width of the hold counter. Must satisfy 2^HOLD_CNT_W > MAX_HOLD.

Ports:
- clk  input  1  system clock; all state is updated on its rising edge.
- reset  input  1  asynchronous, active-low reset.
- m0_req_n  input  1  master 0 bus request, active-low.
- m1_req_n  input  1  master 1 bus request, active-low.
- m2_req_n  input  1  master 2 bus request, active-low.
- m3_req_n  input  1  master 3 bus request, active-low.
- m0_grnt_n  output  1  master 0 grant, active-low.
- m1_grnt_n  output  1  master 1 grant, active-low.
- m2_grnt_n  output  1  master 2 grant, active-low.
- m3_grnt_n  output  1  master 3 grant, active-low.
- bus_owner  output  2  current owner index, 0..3. Drives the master mux select.

Interface note: one clock (clk); reset is asynchronous and active-low (reset).

Behaviour:
- State: owner register (2 bits). Hold counter (HOLD_CNT_W bits) exists only with the optional feature.
- Reset value: while reset is low, asynchronously:
  - owner = 0, so bus_owner = 2'd0
  - m0_grnt_n = ENABLE_ (0); m1/m2/m3_grnt_n = DISABLE_ (1)
  - hold counter = 0
  - Reset asserted mid-transfer aborts ownership immediately, with no handshake.
- Grant generation:
  - Grants and bus_owner are decoded purely from the owner register.
  - Exactly one grant is low at all times, including immediately after reset and when no master is requesting (park on last owner).
  - There is no combinational path from any req_n to any grant.
- Next-owner rule, evaluated every rising edge:
  - If req_n[owner] is low (and the feature is not forcing rotation), owner is unchanged.
  - Otherwise, search indices owner+1, owner+2, owner+3, owner (mod 4) and take the first with req_n low.
  - If no request is asserted, owner is unchanged (parking).
- Latency:
  - A request sampled low at edge N, with the bus free, gives the grant low after edge N, i.e. visible during cycle N+1.
  - If the owner releases (req_n high) in the same cycle another master requests, the handover happens at that single edge. There is no idle cycle between owners.
- Simultaneous requests: resolved solely by rotation order starting after the current owner. There is no fixed priority.
- Wrap-around: index 3 + 1 wraps to 0. Two-bit arithmetic is modulo 4.
- Re-request by the owner right after release: the owner is only re-selected if no other master is requesting (it is searched last).
- Masters must hold req_n low until their transfer finishes. The arbiter does not monitor slave ready.

Optional Feature:
- Macro: BUS_ARB_TIMEOUT_EN.
- Enabled:
  - The hold counter increments each edge that the owner keeps the bus with req_n low, saturating at MAX_HOLD-1.
  - The counter clears to 0 on any owner change, or when the owner's req_n is high.
  - When the counter equals MAX_HOLD-1 and any other master is requesting, the next edge forces the round-robin search starting at owner+1. The current owner is then excluded unless it is the only requester.
  - If no other master is requesting, the owner keeps the bus and the counter stays saturated.
- Disabled: no counter is instantiated; arbitration is purely non-preemptive. MAX_HOLD and HOLD_CNT_W are ignored.

Decomposition:
- Shared bus definitions package (bus_def):
  - BUS_OWNER_BUS (1:0)
  - BUS_OWNER_MASTER_0..3 (2'h0..2'h3)
  - BUS_MASTER_CH (4)
- Global standard definitions supply ENABLE_, DISABLE_ and the reset polarity/edge macros.
- One natural sub-module: bus_arb_rr_pick. It is combinational: inputs are the 4-bit active-high request vector, the current owner and a force_rotate flag; output is the next owner index. It keeps the registered wrapper small and can be unit-tested on its own.

Test Plan:
- Reset, then all req_n = 1 for 5 cycles -> m0_grnt_n = 0, others 1, bus_owner = 0 throughout.
- From owner 0, m2_req_n low at edge N, m0 idle -> bus_owner = 2 and m2_grnt_n = 0 from cycle N+1. A single grant is low every cycle.
- All four req_n low, each master releasing 3 cycles after its grant -> grant sequence 1, 2, 3, 0, 1, each handover in one edge with no gap.
- Owner 3 holding req, m1 requesting for 40 cycles, feature disabled -> owner stays 3. Owner 3 releases at edge K -> bus_owner = 1 after K.
- BUS_ARB_TIMEOUT_EN, MAX_HOLD = 4, owner 0 holding, m1 requesting -> owner switches to 1 after exactly 4 owned cycles. With m1 idle, owner 0 keeps the bus indefinitely.
- Reset pulsed low mid-cycle while owner = 2 -> grants switch to m0 asynchronously before the next clk edge, and the counter reads 0.
